// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide unit with pipeline stall sequencer for the EX stage.
// Optional build macro: MULDIV_EARLY_OUT_EN (skip the iteration loop for zero-operand cases).
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;      // MUL: high word; DIV: partial remainder
    logic [WIDTH-1:0] quot_q, quot_d;    // MUL: low word;  DIV: quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;    // a for multiply, b for divide
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_r_sh;
    logic [WIDTH+1:0] div_t;
    logic [WIDTH-1:0] iter_rem, iter_quot, final_res;
    logic             early_out;
    logic [WIDTH-1:0] early_res;

    // One iteration of whichever datapath the captured op selects.
    always_comb begin
        mul_sum   = {1'b0, rem_q} + (quot_q[0] ? {1'b0, opnd_q} : '0);
        div_r_sh  = {rem_q, quot_q[WIDTH-1]};
        div_t     = {1'b0, div_r_sh} - {2'b00, opnd_q};
        iter_rem  = rem_q;
        iter_quot = quot_q;
        if (op_q[1]) begin
            if (!div_t[WIDTH+1]) begin
                iter_rem  = div_t[WIDTH-1:0];
                iter_quot = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                iter_rem  = div_r_sh[WIDTH-1:0];
                iter_quot = {quot_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            iter_rem  = mul_sum[WIDTH:1];
            iter_quot = {mul_sum[0], quot_q[WIDTH-1:1]};
        end
        // MULHU and REMU take the upper register; MUL and DIVU the lower.
        final_res = op_q[0] ? iter_rem : iter_quot;
    end

    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        early_out = op[1] ? (b == '0) : ((a == '0) || (b == '0));
        early_res = (op == 2'b10) ? '1 : ((op == 2'b11) ? a : '0);
`else
        early_out = 1'b0;
        early_res = '0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        op_d     = op_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d    = op;
                    opnd_d  = op[1] ? b : a;
                    count_d = '0;
                    if (early_out) begin
                        result_d = early_res;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quot_d  = op[1] ? a : b;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q + 1'b1;
                    rem_d   = iter_rem;
                    quot_d  = iter_quot;
                    if (count_q == LAST) begin
                        result_d = final_res;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            op_q     <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign stall  = ((state_q == S_IDLE) && start && !flush) || (state_q == S_RUN);
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against a plain-arithmetic reference model.
module tb_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         stall, busy, done;
    logic [W-1:0] result;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_last = '0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (y == 0) ? {W{1'b1}} : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit early_case(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        return o[1] ? (y == 0) : (x == 0 || y == 0);
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; that cycle is cycle 0 (start sampled at the following edge).
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        int cyc;
        int stall_cnt;
        int exp_lat;
        bit early;
        logic [W-1:0] exp;
        early   = early_case(o, x, y);
        exp_lat = early ? 1 : W + 1;
        exp     = model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        #1;
        stall_cnt = stall ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, "/busy1"}, busy, !early);
        while (!done && cyc < 200) begin
            if (stall) stall_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "/done"}, done, 1);
        check({tag, "/lat"}, cyc, exp_lat);
        check({tag, "/stall_len"}, stall_cnt, exp_lat);
        check({tag, "/stall_in_done"}, stall, 0);
        check({tag, "/res"}, result, exp);
        $display("op=%0d a=0x%0h b=0x%0h result=0x%0h expected=0x%0h latency=%0d (%s)",
                 o, x, y, result, exp, cyc, tag);
        exp_last = exp;
        @(negedge clk);
        check({tag, "/pulse"}, done, 0);
    endtask

    initial begin
        int done_cnt;
        logic [W-1:0] ra, rb;
        logic [1:0] ro;

        #1;
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/result", result, 0);
        check("rst/stall", stall, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'd7, 32'd6, "mul_7x6");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
        run_op(2'b10, 32'd100, 32'd7, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, "remu_100_7");
        run_op(2'b10, 32'd7, 32'd100, "divu_7_100");
        run_op(2'b10, 32'd5, 32'd0, "divu_by0");
        run_op(2'b11, 32'd5, 32'd0, "remu_by0");
        run_op(2'b01, 32'd0, 32'd12345, "mulhu_zero");
        run_op(2'b10, 32'hFFFF_FFFF, 32'd1, "divu_by1");

        // Flush mid-divide: no done pulse, result untouched, next start accepted.
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush/busy", busy, 0);
        check("flush/done", done, 0);
        check("flush/stall", stall, 0);
        check("flush/result", result, exp_last);
        run_op(2'b00, 32'd11, 32'd13, "after_flush");

        // Starts during RUN and DONE are ignored; operands captured only at accept.
        start = 1'b1; op = 2'b00; a = 32'd1234; b = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= 2 * W + 10; c++) begin
            start = (c == 5 || c == W + 1);
            op = 2'b10; a = 32'd9; b = 32'd2;
            #1;
            if (done) done_cnt++;
            if (c == W + 1) begin
                check("ign/done_cycle", done, 1);
                check("ign/stall_done", stall, 0);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ign/done_count", done_cnt, 1);
        check("ign/result", result, 32'd1234 * 32'd5678);
        check("ign/busy_end", busy, 0);
        $display("op=0 a=0x4d2 b=0x162e ignored-starts done_pulses=%0d result=0x%0h", done_cnt, result);

        // start with flush in IDLE is refused.
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
        #1;
        check("idleflush/stall", stall, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idleflush/busy", busy, 0);
        done_cnt = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("idleflush/no_done", done_cnt, 0);
        $display("start+flush in IDLE: done_pulses=%0d", done_cnt);

        // Asynchronous reset mid-run.
        start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst/busy", busy, 0);
        check("arst/done", done, 0);
        check("arst/stall", stall, 0);
        check("arst/result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 32'd3, 32'd3, "mul_3x3");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       ra = '0;
                1:       ra = W'($urandom_range(1, 255));
                default: ra = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 255));
                default: rb = W'($urandom);
            endcase
            run_op(ro, ra, rb, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide unit and its sequencer for the EX stage. It accepts one RV32M-style unsigned operation from the pipeline, runs a shift-add multiply or a restoring divide over WIDTH cycles, and holds the pipeline with a stall request until the result is ready. It sits beside the single-cycle ALU. The EX-stage result mux selects `result` when `done` is high.

## Interface
- WIDTH, 32, operand and result width in bits (power of two, ≥4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
- a  in  WIDTH  multiplicand / dividend, captured with start
- b  in  WIDTH  multiplier / divisor, captured with start
- flush  in  1  abort the current operation (branch mispredict or trap)
- stall  out  1  combinational; holds the IF/ID/EX pipeline registers
- busy  out  1  registered; high in RUN
- done  out  1  registered; one-cycle pulse, result valid
- result  out  WIDTH  registered; holds its value until the next accepted start

## Operation
- Reset values: state=IDLE, busy=0, done=0, result=0, and count, product/remainder and quotient registers all 0.
- States:
  - IDLE: accept when start & ~flush. Capture a, b and op, clear count, go to RUN. With MULDIV_EARLY_OUT_EN, an early-out case goes straight to DONE instead (see Configuration).
  - RUN: one iteration per cycle; count increments. At count==WIDTH-1, write result and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. A start in this cycle is ignored; it is accepted the following cycle.
- stall = (IDLE & start & ~flush) | RUN.
  - stall is low in DONE, so the pipeline advances and captures result.
- MUL/MULHU datapath:
  - 2·WIDTH accumulator {hi, lo}, with lo initialised to b and hi to 0.
  - Each iteration: if lo[0], hi += a, keeping the carry as bit WIDTH. Then shift the (2·WIDTH+1)-bit value right by 1.
  - MUL returns lo; MULHU returns hi.
- DIVU/REMU datapath (restoring):
  - remainder r (WIDTH+1 bits) = 0; quotient q = a.
  - Each iteration: {r,q} <<= 1; t = r − b. If t ≥ 0, r = t and q[0]=1.
  - DIVU returns q; REMU returns r[WIDTH-1:0].
- Divide by zero falls out of the algorithm: DIVU gives all ones and REMU gives a. This matches the RISC-V result without special logic.
- All arithmetic is unsigned and modulo 2^WIDTH. No exceptions or flags are raised.
- flush:
  - In RUN or DONE: next state is IDLE, busy=0, done=0, and result is left unchanged.
  - In IDLE, flush & start: the start is not accepted and stall=0.
- Reset mid-operation: all registers return to reset values immediately (asynchronous).
- start while busy: ignored, with no queuing.

## Timing
- Start sampled at edge 0. RUN occupies cycles 1..WIDTH. done=1 and result valid in cycle WIDTH+1. Latency is WIDTH+1 cycles (33 for WIDTH=32).
- Early-out operations (macro defined): done in cycle 1, latency 1.
- stall is high from the start cycle through the last RUN cycle: WIDTH+1 cycles, or 1 cycle for early-out.
- Back-to-back: minimum issue interval is WIDTH+2 cycles (start, RUN×WIDTH, DONE).

## Configuration
- MULDIV_EARLY_OUT_EN defined: IDLE goes directly to DONE, setting result, in these cases:
  - DIVU/REMU with b==0: result = all ones / a.
  - MUL/MULHU with a==0 or b==0: result = 0.
- Not defined: every operation takes the full WIDTH+1 cycles.
- Results are identical either way; only latency and stall length differ.

## Test plan
- MUL a=7, b=6 → stall high 33 cycles, done in cycle 33, result=42. MULHU a=b=0xFFFFFFFF → result=0xFFFFFFFE.
- DIVU a=100, b=7 → result=14. REMU same operands → result=2. DIVU a=7, b=100 → result=0.
- DIVU a=5, b=0 → 0xFFFFFFFF and REMU → 5. With MULDIV_EARLY_OUT_EN done in cycle 1; without, in cycle 33.
- Start DIVU, assert flush in cycle 10 → busy=0 in cycle 11, no done pulse, result unchanged. A start in cycle 11 is accepted.
- start pulsed in cycles 5 and 33 of a running MUL → both ignored, and exactly one done pulse occurs. A start with flush in IDLE → not accepted, stall=0.
- rst_n low in cycle 15 of a run → busy, done, stall and result are 0 immediately. After release, a new MUL 3×3 → result=9.
